// File: rtl/div_sqrt_issue_mvp_if.sv
// rtl/div_sqrt_issue_mvp_if.sv - handshake and engine bus of the div/sqrt issue sequencer
// slave is the sequencer's view; master is the surrounding dispatcher/engine/consumer view.
interface div_sqrt_issue_mvp_if #(
  parameter int C_MANT_W     = 53,
  parameter int C_EXP_W      = 12,
  parameter int C_RES_MANT_W = 57,
  parameter int C_RES_EXP_W  = 13,
  parameter int C_TAG_W      = 4,
  parameter int C_PC         = 6
) ();
  logic                    In_valid_SI;
  logic                    In_ready_SO;
  logic                    Op_sqrt_SI;
  logic [1:0]              Format_sel_SI;
  logic [C_PC-1:0]         Precision_ctl_SI;
  logic [C_MANT_W-1:0]     Opa_mant_DI;
  logic [C_MANT_W-1:0]     Opb_mant_DI;
  logic [C_EXP_W-1:0]      Opa_exp_DI;
  logic [C_EXP_W-1:0]      Opb_exp_DI;
  logic [C_TAG_W-1:0]      Tag_DI;
  logic                    Kill_SI;
  logic                    Start_SO;
  logic                    Div_start_SO;
  logic                    Sqrt_start_SO;
  logic                    Kill_SO;
  logic [C_MANT_W-1:0]     Numerator_DO;
  logic [C_MANT_W-1:0]     Denominator_DO;
  logic [C_EXP_W-1:0]      Exp_num_DO;
  logic [C_EXP_W-1:0]      Exp_den_DO;
  logic [1:0]              Format_sel_SO;
  logic [C_PC-1:0]         Precision_ctl_SO;
  logic                    Ready_SI;
  logic                    Done_SI;
  logic [C_RES_MANT_W-1:0] Mant_result_prenorm_DI;
  logic [C_RES_EXP_W-1:0]  Exp_result_prenorm_DI;
  logic                    Out_valid_SO;
  logic                    Out_ready_SI;
  logic [C_RES_MANT_W-1:0] Mant_res_DO;
  logic [C_RES_EXP_W-1:0]  Exp_res_DO;
  logic [C_TAG_W-1:0]      Tag_DO;
  logic                    Timeout_SO;
  logic                    Busy_SO;

  modport slave (
    input  In_valid_SI, Op_sqrt_SI, Format_sel_SI, Precision_ctl_SI,
           Opa_mant_DI, Opb_mant_DI, Opa_exp_DI, Opb_exp_DI, Tag_DI, Kill_SI,
           Ready_SI, Done_SI, Mant_result_prenorm_DI, Exp_result_prenorm_DI,
           Out_ready_SI,
    output In_ready_SO, Start_SO, Div_start_SO, Sqrt_start_SO, Kill_SO,
           Numerator_DO, Denominator_DO, Exp_num_DO, Exp_den_DO,
           Format_sel_SO, Precision_ctl_SO, Out_valid_SO, Mant_res_DO,
           Exp_res_DO, Tag_DO, Timeout_SO, Busy_SO
  );

  modport master (
    output In_valid_SI, Op_sqrt_SI, Format_sel_SI, Precision_ctl_SI,
           Opa_mant_DI, Opb_mant_DI, Opa_exp_DI, Opb_exp_DI, Tag_DI, Kill_SI,
           Ready_SI, Done_SI, Mant_result_prenorm_DI, Exp_result_prenorm_DI,
           Out_ready_SI,
    input  In_ready_SO, Start_SO, Div_start_SO, Sqrt_start_SO, Kill_SO,
           Numerator_DO, Denominator_DO, Exp_num_DO, Exp_den_DO,
           Format_sel_SO, Precision_ctl_SO, Out_valid_SO, Mant_res_DO,
           Exp_res_DO, Tag_DO, Timeout_SO, Busy_SO
  );
endinterface

// File: rtl/div_sqrt_issue_mvp.sv
// rtl/div_sqrt_issue_mvp.sv - issue-side sequencer for the iterative div/sqrt engine
// Optional WAIT watchdog enabled by defining DIV_SQRT_ISSUE_TIMEOUT_EN.
module div_sqrt_issue_mvp #(
  parameter int C_MANT_W     = 53,
  parameter int C_EXP_W      = 12,
  parameter int C_RES_MANT_W = 57,
  parameter int C_RES_EXP_W  = 13,
  parameter int C_TAG_W      = 4,
  parameter int C_PC         = 6,
  parameter int C_TIMEOUT    = 127
) (
  input  logic                Clk_CI,
  input  logic                Rst_RBI,
  div_sqrt_issue_mvp_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic                    r_op_sqrt;
  logic [1:0]              r_fmt;
  logic [C_PC-1:0]         r_prec;
  logic [C_MANT_W-1:0]     r_opa;
  logic [C_MANT_W-1:0]     r_opb;
  logic [C_EXP_W-1:0]      r_expa;
  logic [C_EXP_W-1:0]      r_expb;
  logic [C_TAG_W-1:0]      r_tag;
  logic [C_RES_MANT_W-1:0] r_mant_res;
  logic [C_RES_EXP_W-1:0]  r_exp_res;
  logic [C_TAG_W-1:0]      r_tag_res;
  logic                    r_timeout;

  logic w_accept;
  logic w_kill;
  logic w_fire;
  logic w_done;
  logic w_tmo;
  logic w_in_ready;
  logic w_out_valid;
  logic w_busy;
  logic w_kill_pulse;

  assign w_accept = (r_state == S_IDLE) && io_bus.In_valid_SI;
  assign w_kill   = io_bus.Kill_SI && ((r_state == S_ISSUE) || (r_state == S_WAIT));
  // Kill outranks both Ready and Done in the same cycle.
  assign w_fire   = (r_state == S_ISSUE) && io_bus.Ready_SI && !io_bus.Kill_SI;
  assign w_done   = (r_state == S_WAIT) && io_bus.Done_SI && !io_bus.Kill_SI;

`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
  localparam int C_CNT_W = (C_TIMEOUT < 1) ? 1 : $clog2(C_TIMEOUT + 1);

  logic [C_CNT_W-1:0] r_wait_cnt;

  // Holding the count at zero throughout ISSUE makes it zero on WAIT entry.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + C_CNT_W'(1);
    end
  end

  assign w_tmo = (r_state == S_WAIT) && !io_bus.Done_SI && !io_bus.Kill_SI &&
                 (r_wait_cnt == C_CNT_W'(C_TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (C_TIMEOUT != 0);
  assign w_tmo            = 1'b0;
`endif

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b1;
    w_kill_pulse = w_kill || w_tmo;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (io_bus.In_valid_SI) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (io_bus.Kill_SI) begin
          w_state_nxt = S_IDLE;
        end else if (io_bus.Ready_SI) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (io_bus.Kill_SI) begin
          w_state_nxt = S_IDLE;
        end else if (io_bus.Done_SI || w_tmo) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_out_valid = 1'b1;
        if (io_bus.Out_ready_SI) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operands stay on the engine inputs until the next accept.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_op_sqrt <= 1'b0;
      r_fmt     <= '0;
      r_prec    <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_expa    <= '0;
      r_expb    <= '0;
      r_tag     <= '0;
    end else if (w_accept) begin
      r_op_sqrt <= io_bus.Op_sqrt_SI;
      r_fmt     <= io_bus.Format_sel_SI;
      r_prec    <= io_bus.Precision_ctl_SI;
      r_opa     <= io_bus.Opa_mant_DI;
      r_opb     <= io_bus.Opb_mant_DI;
      r_expa    <= io_bus.Opa_exp_DI;
      r_expb    <= io_bus.Opb_exp_DI;
      r_tag     <= io_bus.Tag_DI;
    end
  end

  // A killed operation leaves the previously held result untouched.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_mant_res <= '0;
      r_exp_res  <= '0;
      r_tag_res  <= '0;
      r_timeout  <= 1'b0;
    end else if (w_done) begin
      r_mant_res <= io_bus.Mant_result_prenorm_DI;
      r_exp_res  <= io_bus.Exp_result_prenorm_DI;
      r_tag_res  <= r_tag;
      r_timeout  <= 1'b0;
    end else if (w_tmo) begin
      r_mant_res <= '0;
      r_exp_res  <= '0;
      r_tag_res  <= r_tag;
      r_timeout  <= 1'b1;
    end
  end

  assign io_bus.In_ready_SO      = w_in_ready;
  assign io_bus.Start_SO         = w_fire;
  assign io_bus.Div_start_SO     = w_fire && !r_op_sqrt;
  assign io_bus.Sqrt_start_SO    = w_fire && r_op_sqrt;
  assign io_bus.Kill_SO          = w_kill_pulse;
  assign io_bus.Numerator_DO     = r_opa;
  assign io_bus.Denominator_DO   = r_opb;
  assign io_bus.Exp_num_DO       = r_expa;
  assign io_bus.Exp_den_DO       = r_expb;
  assign io_bus.Format_sel_SO    = r_fmt;
  assign io_bus.Precision_ctl_SO = r_prec;
  assign io_bus.Out_valid_SO     = w_out_valid;
  assign io_bus.Mant_res_DO      = r_mant_res;
  assign io_bus.Exp_res_DO       = r_exp_res;
  assign io_bus.Tag_DO           = r_tag_res;
  assign io_bus.Timeout_SO       = r_timeout;
  assign io_bus.Busy_SO          = w_busy;

endmodule

// File: tb/tb_div_sqrt_issue_mvp.sv
// tb/tb_div_sqrt_issue_mvp.sv - self-checking bench for the div/sqrt issue sequencer
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_div_sqrt_issue_mvp;
  localparam int MW  = 53;
  localparam int EW  = 12;
  localparam int RMW = 57;
  localparam int REW = 13;
  localparam int TW  = 4;
  localparam int PCW = 6;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_sqrt_issue_mvp_if #(
    .C_MANT_W(MW), .C_EXP_W(EW), .C_RES_MANT_W(RMW), .C_RES_EXP_W(REW),
    .C_TAG_W(TW), .C_PC(PCW)
  ) bus ();

  div_sqrt_issue_mvp #(
    .C_MANT_W(MW), .C_EXP_W(EW), .C_RES_MANT_W(RMW), .C_RES_EXP_W(REW),
    .C_TAG_W(TW), .C_PC(PCW), .C_TIMEOUT(TMO)
  ) dut (
    .Clk_CI (clk),
    .Rst_RBI(rst_n),
    .io_bus (bus)
  );

  typedef struct {
    logic           sqrt;
    logic [1:0]     fmt;
    logic [PCW-1:0] pc;
    logic [TW-1:0]  tag;
    logic [MW-1:0]  opa;
    logic [MW-1:0]  opb;
    logic [EW-1:0]  ea;
    logic [EW-1:0]  eb;
    int             rdy_dly;
    int             lat;
    int             stall;
    logic [RMW-1:0] mant;
    logic [REW-1:0] ex;
    logic           e_div;
    logic           e_sqrt;
    logic [TW-1:0]  e_tag;
    logic [RMW-1:0] e_mant;
    logic [REW-1:0] e_exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RMW-1:0] last_mant = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: a sequencer is transparent to data, the
  // start flavour follows the op, and the result carries the issue tag.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_div  = !v.sqrt;
    r.e_sqrt = v.sqrt;
    r.e_tag  = v.tag;
    r.e_mant = v.mant;
    r.e_exp  = v.ex;
    return r;
  endfunction

  task automatic clear_inputs();
    bus.In_valid_SI = 0; bus.Op_sqrt_SI = 0; bus.Format_sel_SI = 0;
    bus.Precision_ctl_SI = 0; bus.Opa_mant_DI = 0; bus.Opb_mant_DI = 0;
    bus.Opa_exp_DI = 0; bus.Opb_exp_DI = 0; bus.Tag_DI = 0; bus.Kill_SI = 0;
    bus.Ready_SI = 0; bus.Done_SI = 0; bus.Mant_result_prenorm_DI = 0;
    bus.Exp_result_prenorm_DI = 0; bus.Out_ready_SI = 0;
  endtask

  task automatic accept(input vec_t v, input string nm);
    bus.In_valid_SI = 1; bus.Op_sqrt_SI = v.sqrt; bus.Format_sel_SI = v.fmt;
    bus.Precision_ctl_SI = v.pc; bus.Opa_mant_DI = v.opa; bus.Opb_mant_DI = v.opb;
    bus.Opa_exp_DI = v.ea; bus.Opb_exp_DI = v.eb; bus.Tag_DI = v.tag;
    #1;
    chk({nm, "/in_ready"}, 64'(bus.In_ready_SO), 64'd1);
    @(negedge clk);
    bus.In_valid_SI = 0; bus.Opa_mant_DI = ~v.opa; bus.Opb_mant_DI = ~v.opb;
    bus.Opa_exp_DI = ~v.ea; bus.Opb_exp_DI = ~v.eb; bus.Tag_DI = ~v.tag;
    bus.Op_sqrt_SI = ~v.sqrt;
  endtask

  task automatic run_op(input vec_t v, input string nm);
    accept(v, nm);
    for (int i = 0; i < v.rdy_dly; i++) begin
      bus.Ready_SI = 0; #1;
      chk({nm, "/no_start"}, 64'({bus.Start_SO, bus.Div_start_SO, bus.Sqrt_start_SO}), 64'd0);
      chk({nm, "/stall_busy"}, 64'({bus.Busy_SO, bus.In_ready_SO}), 64'b10);
      @(negedge clk);
    end
    bus.Ready_SI = 1; #1;
    chk({nm, "/start"}, 64'(bus.Start_SO), 64'd1);
    chk({nm, "/div_start"}, 64'(bus.Div_start_SO), 64'(v.e_div));
    chk({nm, "/sqrt_start"}, 64'(bus.Sqrt_start_SO), 64'(v.e_sqrt));
    chk({nm, "/num"}, 64'(bus.Numerator_DO), 64'(v.opa));
    chk({nm, "/den"}, 64'(bus.Denominator_DO), 64'(v.opb));
    chk({nm, "/exps"}, 64'({bus.Exp_num_DO, bus.Exp_den_DO}), 64'({v.ea, v.eb}));
    chk({nm, "/ctl"}, 64'({bus.Format_sel_SO, bus.Precision_ctl_SO}), 64'({v.fmt, v.pc}));
    @(negedge clk);
    bus.Ready_SI = 0;
    for (int i = 0; i < v.lat; i++) begin
      #1;
      chk({nm, "/wait_quiet"}, 64'({bus.Start_SO, bus.Out_valid_SO, bus.Kill_SO}), 64'd0);
      @(negedge clk);
    end
    bus.Done_SI = 1; bus.Mant_result_prenorm_DI = v.mant; bus.Exp_result_prenorm_DI = v.ex;
    #1;
    chk({nm, "/done_not_valid"}, 64'(bus.Out_valid_SO), 64'd0);
    @(negedge clk);
    bus.Done_SI = 0; bus.Mant_result_prenorm_DI = ~v.mant; bus.Exp_result_prenorm_DI = ~v.ex;
    for (int i = 0; i < v.stall; i++) begin
      bus.Out_ready_SI = 0; bus.Kill_SI = (i == 0); #1;
      chk({nm, "/hold_valid"}, 64'({bus.Out_valid_SO, bus.In_ready_SO, bus.Kill_SO}), 64'b100);
      chk({nm, "/hold_mant"}, 64'(bus.Mant_res_DO), 64'(v.e_mant));
      chk({nm, "/hold_tag"}, 64'(bus.Tag_DO), 64'(v.e_tag));
      @(negedge clk);
      bus.Kill_SI = 0;
    end
    bus.Out_ready_SI = 1; #1;
    chk({nm, "/out_valid"}, 64'(bus.Out_valid_SO), 64'd1);
    chk({nm, "/out_mant"}, 64'(bus.Mant_res_DO), 64'(v.e_mant));
    chk({nm, "/out_exp"}, 64'(bus.Exp_res_DO), 64'(v.e_exp));
    chk({nm, "/out_tag"}, 64'(bus.Tag_DO), 64'(v.e_tag));
    chk({nm, "/timeout"}, 64'(bus.Timeout_SO), 64'd0);
    @(negedge clk);
    bus.Out_ready_SI = 0; #1;
    chk({nm, "/back_idle"}, 64'({bus.In_ready_SO, bus.Out_valid_SO, bus.Busy_SO}), 64'b100);
    last_mant = v.e_mant;
  endtask

  vec_t tbl[4];
  vec_t v;

  initial begin
    clear_inputs();
    tbl[0] = '{1'b0, 2'd1, 6'd52, 4'h5, 53'h1F_0000_1234_5678, 53'h10_0000_0000_0001,
               12'h400, 12'h3FE, 0, 3, 0, 57'h10_0000_0000_0000, 13'h3FF,
               1'b1, 1'b0, 4'h5, 57'h10_0000_0000_0000, 13'h3FF};
    tbl[1] = '{1'b1, 2'd2, 6'd23, 4'hA, 53'h15_5555_5555_5555, 53'h0,
               12'h0FF, 12'h000, 10, 5, 0, 57'h0AB_CDEF_0123_4567, 13'h0801,
               1'b0, 1'b1, 4'hA, 57'h0AB_CDEF_0123_4567, 13'h0801};
    tbl[2] = '{1'b0, 2'd0, 6'd11, 4'h3, 53'h1, 53'h1F_FFFF_FFFF_FFFF,
               12'hFFF, 12'h001, 2, 1, 5, 57'h0, 13'h1000,
               1'b1, 1'b0, 4'h3, 57'h0, 13'h1000};
    tbl[3] = '{1'b1, 2'd3, 6'd63, 4'hF, 53'h1F_FFFF_FFFF_FFFF, 53'h1F_FFFF_FFFF_FFFF,
               12'h7FF, 12'h7FF, 0, 0, 1, 57'h1FF_FFFF_FFFF_FFFF, 13'h1FFF,
               1'b0, 1'b1, 4'hF, 57'h1FF_FFFF_FFFF_FFFF, 13'h1FFF};

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst/num", 64'(bus.Numerator_DO), 64'd0);
    chk("rst/den", 64'(bus.Denominator_DO), 64'd0);
    chk("rst/exps", 64'({bus.Exp_num_DO, bus.Exp_den_DO}), 64'd0);
    chk("rst/ctl", 64'({bus.Format_sel_SO, bus.Precision_ctl_SO}), 64'd0);
    chk("rst/res", 64'({bus.Mant_res_DO, bus.Exp_res_DO}), 64'd0);
    chk("rst/tag_to", 64'({bus.Tag_DO, bus.Timeout_SO}), 64'd0);
    chk("rst/pulses", 64'({bus.Start_SO, bus.Div_start_SO, bus.Sqrt_start_SO, bus.Kill_SO}), 64'd0);
    chk("rst/status", 64'({bus.Out_valid_SO, bus.Busy_SO}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rst/in_ready", 64'(bus.In_ready_SO), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Done while IDLE is ignored
    bus.Done_SI = 1; bus.Mant_result_prenorm_DI = 57'h123; #1;
    @(negedge clk);
    bus.Done_SI = 0; #1;
    chk("idle_done/valid", 64'({bus.Out_valid_SO, bus.Busy_SO}), 64'd0);
    chk("idle_done/mant", 64'(bus.Mant_res_DO), 64'(last_mant));
    @(negedge clk);

    // Kill and Done together in WAIT
    v = tbl[0]; v.tag = 4'h9;
    accept(v, "kd");
    bus.Ready_SI = 1; @(negedge clk); bus.Ready_SI = 0;
    bus.Kill_SI = 1; bus.Done_SI = 1; bus.Mant_result_prenorm_DI = 57'h77; #1;
    chk("kd/kill_so", 64'({bus.Kill_SO, bus.Out_valid_SO}), 64'b10);
    @(negedge clk);
    bus.Kill_SI = 0; bus.Done_SI = 0; #1;
    chk("kd/idle", 64'({bus.In_ready_SO, bus.Out_valid_SO, bus.Busy_SO, bus.Kill_SO}), 64'b1000);
    chk("kd/mant_kept", 64'(bus.Mant_res_DO), 64'(last_mant));
    @(negedge clk);

    // Kill and Ready together in ISSUE
    accept(tbl[1], "ki");
    bus.Ready_SI = 1; bus.Kill_SI = 1; #1;
    chk("ki/no_start", 64'({bus.Start_SO, bus.Sqrt_start_SO}), 64'd0);
    chk("ki/kill_so", 64'(bus.Kill_SO), 64'd1);
    @(negedge clk);
    bus.Ready_SI = 0; bus.Kill_SI = 0; #1;
    chk("ki/idle", 64'({bus.In_ready_SO, bus.Busy_SO}), 64'b10);
    @(negedge clk);

    // Randomized operations against the reference model
    for (int i = 0; i < 16; i++) begin
      v.sqrt = 1'($urandom_range(0, 1)); v.fmt = 2'($urandom); v.pc = PCW'($urandom);
      v.tag = TW'($urandom); v.opa = MW'({$urandom(), $urandom()});
      v.opb = MW'({$urandom(), $urandom()}); v.ea = EW'($urandom); v.eb = EW'($urandom);
      v.rdy_dly = $urandom_range(0, 3); v.lat = $urandom_range(0, 6);
      v.stall = $urandom_range(0, 3); v.mant = RMW'({$urandom(), $urandom()});
      v.ex = REW'($urandom);
      run_op(model(v), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of WAIT
    accept(tbl[3], "ar");
    bus.Ready_SI = 1; @(negedge clk); bus.Ready_SI = 0;
    #2; rst_n = 1'b0; #1;
    chk("ar/operands", 64'({bus.Numerator_DO, bus.Exp_num_DO}), 64'd0);
    chk("ar/result", 64'({bus.Mant_res_DO, bus.Tag_DO}), 64'd0);
    chk("ar/pulses", 64'({bus.Kill_SO, bus.Start_SO, bus.Out_valid_SO, bus.Busy_SO}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("ar/released", 64'({bus.In_ready_SO, bus.Kill_SO}), 64'b10);
    @(negedge clk);

`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
    v = tbl[2]; v.tag = 4'hC;
    accept(v, "to");
    bus.Ready_SI = 1; @(negedge clk); bus.Ready_SI = 0;
    for (int i = 0; i < TMO; i++) begin
      #1;
      chk("to/early_kill", 64'(bus.Kill_SO), 64'd0);
      @(negedge clk);
    end
    #1;
    chk("to/kill_so", 64'({bus.Kill_SO, bus.Out_valid_SO}), 64'b10);
    @(negedge clk);
    bus.Out_ready_SI = 1; #1;
    chk("to/valid_flag", 64'({bus.Out_valid_SO, bus.Timeout_SO}), 64'b11);
    chk("to/zero_res", 64'({bus.Mant_res_DO, bus.Exp_res_DO}), 64'd0);
    chk("to/tag", 64'(bus.Tag_DO), 64'hC);
    @(negedge clk);
    bus.Out_ready_SI = 0;
    run_op(tbl[0], "after_to");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
